vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised, counter-based VGA raster timing generator; successor to the fixed 1024x768 FSM generator.
- Holds two compile-time timing modes (A, B), selected at runtime and switched only at frame boundaries.
- Adds programmable sync polarity, a pixel-enable input, frame/line strobes and an output delay line to align syncs with downstream pixel-pipeline latency.
- Sits between the clock/PLL and the pixel renderer / DAC driver.

Parameters:
- XW, 12, width of pixel_x and horizontal counter
- YW, 11, width of pixel_y and vertical counter
- A_H_ACT/A_H_FP/A_H_SYNC/A_H_BP, 1024/24/136/160, mode A horizontal timing (clocks)
- A_V_ACT/A_V_FP/A_V_SYNC/A_V_BP, 768/3/6/29, mode A vertical timing (lines)
- A_HPOL/A_VPOL, 0/0, mode A sync polarity (0 = active-low)
- B_H_ACT/B_H_FP/B_H_SYNC/B_H_BP, 640/16/96/48, mode B horizontal timing
- B_V_ACT/B_V_FP/B_V_SYNC/B_V_BP, 480/10/2/33, mode B vertical timing
- B_HPOL/B_VPOL, 0/0, mode B sync polarity
- LATENCY, 0, output delay in pixel-enabled cycles, range 0..7

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- pix_en  in  1  clock enable; counters and delay line advance only when 1
- mode_sel  in  1  requested mode (0 = A, 1 = B); sampled at frame wrap only
- hsync  out  1  horizontal sync, polarity per current mode
- vsync  out  1  vertical sync, polarity per current mode
- active_video  out  1  high inside the active area
- pixel_x  out  XW  column; 0 outside the active area
- pixel_y  out  YW  row; 0 outside the active area
- line_start  out  1  one-cycle pulse at h=0
- frame_start  out  1  one-cycle pulse at h=0, v=0
- mode_cur  out  1  mode in effect for the current frame

Behaviour:
- Reset (async): h_cnt=0, v_cnt=0, mode_cur=0; delay line flushed; hsync/vsync at inactive level of mode A; active_video, pixel_x, pixel_y, line_start, frame_start = 0.
- Counting (pix_en=1 only): h_cnt increments 0..H_TOT-1, where H_TOT = ACT+FP+SYNC+BP of mode_cur. At H_TOT-1, h_cnt wraps to 0 and v_cnt increments 0..V_TOT-1, wrapping to 0. With pix_en=0, all state holds, outputs hold, and strobes are 0.
- Line order: active, front porch, sync, back porch. Frame order matches.
- Undelayed outputs:
  - act = (h_cnt < H_ACT) && (v_cnt < V_ACT)
  - hs_raw = (H_ACT+H_FP <= h_cnt < H_ACT+H_FP+H_SYNC)
  - vs_raw = (V_ACT+V_FP <= v_cnt < V_ACT+V_FP+V_SYNC), asserted for whole lines
  - hsync = hs_raw XNOR HPOL, i.e. the asserted level equals HPOL; vsync likewise
  - pixel_x = act ? h_cnt : 0; pixel_y = act ? v_cnt : 0
  - line_start = pix_en && h_cnt==0; frame_start = line_start && v_cnt==0
- Mode switch: mode_sel is sampled only in the cycle where pix_en=1, h_cnt=H_TOT-1 and v_cnt=V_TOT-1. mode_cur updates on that edge, so the next frame uses the new timing from (0,0). A mode_sel change mid-frame has no effect until the wrap.
- First frame after reset release: (0,0) is presented immediately, i.e. frame_start fires on the first pix_en=1 cycle.
- LATENCY=N: every output except mode_cur passes through an N-stage shift register clocked on pix_en. With N=0 there is no delay. Strobes are delayed as data and remain one pix_en cycle wide.
- Widths: counters are XW/YW bits. Static assertion: every H_TOT <= 2^XW and every V_TOT <= 2^YW; every FP/SYNC/BP >= 1.
- Reset mid-frame returns to (0,0), mode A, with the pipeline flushed. There is no partial-line output.

Decomposition:
- Package vga_pkg: mode_t enum {MODE_A, MODE_B}; struct vga_timing_t {h_act, h_fp, h_sync, h_bp, v_act, v_fp, v_sync, v_bp, hpol, vpol}; function timing_of(mode_t) returning the parameter set; derived-total helper functions.
- Sub-module vga_out_delay (parametrised width, depth, enable), holding the shift register for the output bundle.

Test Plan:
- Mode A, LATENCY=0, pix_en=1 constant -> line period 1344 clocks; hsync low on h=1048..1183; frame period 806 lines; vsync low on lines 771..776; active count per frame = 786432.
- mode_sel 0→1 at mid-frame -> mode_cur stays 0 until the wrap at (1343,805), then becomes 1; next line period 800, frame 525 lines; vsync low on lines 490..491.
- pix_en toggled 1,0,1,0 -> counters advance on pix_en=1 only; line_start high exactly once per line, frame_start once per frame; all outputs stable during pix_en=0.
- LATENCY=3 vs LATENCY=0 (two instances, same stimulus) -> every delayed output equals the reference output from 3 enabled cycles earlier; reset values shown for the first 3 enabled cycles.
- Mode B with B_HPOL=1, B_VPOL=1 -> hsync high only on h=656..751; vsync high only on lines 490..491.
- Async reset asserted at h=500, v=300 -> immediately hsync/vsync inactive, active_video=0, pixel_x=pixel_y=0, mode_cur=0; after release, frame_start on the first enabled cycle with pixel (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and timing helpers for the VGA raster timing generator.
package vga_pkg;

  typedef enum logic {
    MODE_A = 1'b0,
    MODE_B = 1'b1
  } mode_t;

  // One complete timing set; horizontal values in clocks, vertical in lines.
  typedef struct packed {
    int unsigned h_act;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_act;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hpol;
    logic        vpol;
  } vga_timing_t;

  // Timing set for a mode, chosen between the two compile-time sets.
  function automatic vga_timing_t timing_of(mode_t m, vga_timing_t a, vga_timing_t b);
    return (m == MODE_B) ? b : a;
  endfunction

  function automatic int unsigned h_total(vga_timing_t t);
    return t.h_act + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int unsigned v_total(vga_timing_t t);
    return t.v_act + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  // Porches and sync must all be non-empty for the line order to hold.
  function automatic bit timing_ok(vga_timing_t t);
    return (t.h_fp >= 1) && (t.h_sync >= 1) && (t.h_bp >= 1) &&
           (t.v_fp >= 1) && (t.v_sync >= 1) && (t.v_bp >= 1);
  endfunction

endpackage

// File: rtl/vga_timing_gen_delay.sv
// vga_out_delay: enable-gated shift register that delays the output bundle.
module vga_out_delay #(
  parameter int unsigned     Width  = 1,
  parameter int unsigned     Depth  = 0,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  if (Depth == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset ^ en;
    assign q = d;
  end else begin : g_pipe
    logic [Width-1:0] stage_q [Depth];

    // Shift one stage per enabled cycle; reset loads the idle bundle into every stage.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          stage_q[i] <= RstVal;
        end
      end else if (en) begin
        stage_q[0] <= d;
        for (int unsigned i = 1; i < Depth; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Counter-based VGA raster timing generator with two runtime-selectable modes,
// frame-boundary mode switching, programmable sync polarity and an output delay line.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned XW       = 12,
  parameter int unsigned YW       = 11,
  parameter int unsigned A_H_ACT  = 1024,
  parameter int unsigned A_H_FP   = 24,
  parameter int unsigned A_H_SYNC = 136,
  parameter int unsigned A_H_BP   = 160,
  parameter int unsigned A_V_ACT  = 768,
  parameter int unsigned A_V_FP   = 3,
  parameter int unsigned A_V_SYNC = 6,
  parameter int unsigned A_V_BP   = 29,
  parameter bit          A_HPOL   = 1'b0,
  parameter bit          A_VPOL   = 1'b0,
  parameter int unsigned B_H_ACT  = 640,
  parameter int unsigned B_H_FP   = 16,
  parameter int unsigned B_H_SYNC = 96,
  parameter int unsigned B_H_BP   = 48,
  parameter int unsigned B_V_ACT  = 480,
  parameter int unsigned B_V_FP   = 10,
  parameter int unsigned B_V_SYNC = 2,
  parameter int unsigned B_V_BP   = 33,
  parameter bit          B_HPOL   = 1'b0,
  parameter bit          B_VPOL   = 1'b0,
  parameter int unsigned LATENCY  = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          mode_sel,
  output logic          hsync,
  output logic          vsync,
  output logic          active_video,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          mode_cur
);

  localparam vga_timing_t TimA = '{
    h_act: A_H_ACT, h_fp: A_H_FP, h_sync: A_H_SYNC, h_bp: A_H_BP,
    v_act: A_V_ACT, v_fp: A_V_FP, v_sync: A_V_SYNC, v_bp: A_V_BP,
    hpol: A_HPOL, vpol: A_VPOL
  };
  localparam vga_timing_t TimB = '{
    h_act: B_H_ACT, h_fp: B_H_FP, h_sync: B_H_SYNC, h_bp: B_H_BP,
    v_act: B_V_ACT, v_fp: B_V_FP, v_sync: B_V_SYNC, v_bp: B_V_BP,
    hpol: B_HPOL, vpol: B_VPOL
  };

  // Bundle layout: {hsync, vsync, active, x, y, line_start, frame_start}.
  localparam int unsigned BW = 5 + XW + YW;
  localparam logic [BW-1:0] RstBundle = {~A_HPOL, ~A_VPOL, {(BW-2){1'b0}}};

  // Elaboration-time range checks on the timing sets.
  if (h_total(TimA) > 2**XW || h_total(TimB) > 2**XW) begin : g_chk_xw
    $error("horizontal total exceeds counter width XW");
  end
  if (v_total(TimA) > 2**YW || v_total(TimB) > 2**YW) begin : g_chk_yw
    $error("vertical total exceeds counter width YW");
  end
  if (!timing_ok(TimA) || !timing_ok(TimB)) begin : g_chk_porch
    $error("front porch, sync and back porch must each be at least 1");
  end
  if (LATENCY > 7) begin : g_chk_lat
    $error("LATENCY must be in 0..7");
  end

  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  mode_t         mode_q, mode_d;
  logic          started_q, started_d;

  vga_timing_t   tim;
  logic [31:0]   hx, vy;
  logic          h_last, v_last;
  logic          en_eff, show;
  logic          act, hs_raw, vs_raw;
  logic [BW-1:0] raw_bundle, dly_bundle;
  logic          dly_ls, dly_fs;

  assign tim    = timing_of(mode_q, TimA, TimB);
  assign hx     = 32'(h_q);
  assign vy     = 32'(v_q);
  assign h_last = (hx == h_total(tim) - 1);
  assign v_last = (vy == v_total(tim) - 1);

  // Reset forces idle outputs even though the counters already sit at (0,0).
  assign en_eff = pix_en & ~reset;
  // (0,0) is shown from the first enabled cycle after reset, then held.
  assign show   = started_q | en_eff;

  // Raster position, mode and started flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q       <= '0;
      v_q       <= '0;
      mode_q    <= MODE_A;
      started_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      mode_q    <= mode_d;
      started_q <= started_d;
    end
  end

  // Advance the raster on enabled cycles; mode_sel is taken only at the frame wrap.
  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    mode_d    = mode_q;
    started_d = started_q;
    if (pix_en) begin
      started_d = 1'b1;
      if (h_last) begin
        h_d = '0;
        if (v_last) begin
          v_d    = '0;
          mode_d = mode_t'(mode_sel);
        end else begin
          v_d = v_q + YW'(1);
        end
      end else begin
        h_d = h_q + XW'(1);
      end
    end
  end

  // Undelayed outputs decoded from the raster position.
  always_comb begin
    act    = show && (hx < tim.h_act) && (vy < tim.v_act);
    hs_raw = (hx >= tim.h_act + tim.h_fp) && (hx < tim.h_act + tim.h_fp + tim.h_sync);
    vs_raw = (vy >= tim.v_act + tim.v_fp) && (vy < tim.v_act + tim.v_fp + tim.v_sync);
    raw_bundle = {
      ~(hs_raw ^ tim.hpol),
      ~(vs_raw ^ tim.vpol),
      act,
      act ? h_q : '0,
      act ? v_q : '0,
      en_eff && (h_q == '0),
      en_eff && (h_q == '0) && (v_q == '0)
    };
  end

  vga_out_delay #(
    .Width (BW),
    .Depth (LATENCY),
    .RstVal(RstBundle)
  ) u_delay (
    .clk  (clk),
    .reset(reset),
    .en   (pix_en),
    .d    (raw_bundle),
    .q    (dly_bundle)
  );

  assign {hsync, vsync, active_video, pixel_x, pixel_y, dly_ls, dly_fs} = dly_bundle;
  // Delayed strobes stay one enabled cycle wide.
  assign line_start  = dly_ls & pix_en;
  assign frame_start = dly_fs & pix_en;
  assign mode_cur    = (mode_q == MODE_B);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three generator instances (small timings, small timings with
// LATENCY=3 and inverted mode-B polarity, default 1024x768/640x480 timings).
module tb_vga_timing_gen;
  localparam int XW = 12;
  localparam int YW = 11;

  // Timing tables {h_act, h_fp, h_sync, h_bp, v_act, v_fp, v_sync, v_bp}.
  localparam int SA[8] = '{16, 2, 3, 3, 10, 1, 2, 2};
  localparam int SB[8] = '{10, 1, 2, 1, 6, 1, 1, 2};
  localparam int DA[8] = '{1024, 24, 136, 160, 768, 3, 6, 29};
  localparam int DB[8] = '{640, 16, 96, 48, 480, 10, 2, 33};

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          act;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          ls;
    logic          fs;
    logic          mc;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic mode_sel = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]         hs, vs, av, ls, fs, mc;
  logic [2:0][XW-1:0] px;
  logic [2:0][YW-1:0] py;

  vga_timing_gen #(
    .A_H_ACT(16), .A_H_FP(2), .A_H_SYNC(3), .A_H_BP(3),
    .A_V_ACT(10), .A_V_FP(1), .A_V_SYNC(2), .A_V_BP(2),
    .B_H_ACT(10), .B_H_FP(1), .B_H_SYNC(2), .B_H_BP(1),
    .B_V_ACT(6),  .B_V_FP(1), .B_V_SYNC(1), .B_V_BP(2),
    .LATENCY(0)
  ) u_small (
    .clk(clk), .reset(reset), .pix_en(pix_en), .mode_sel(mode_sel),
    .hsync(hs[0]), .vsync(vs[0]), .active_video(av[0]), .pixel_x(px[0]), .pixel_y(py[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .mode_cur(mc[0])
  );

  vga_timing_gen #(
    .A_H_ACT(16), .A_H_FP(2), .A_H_SYNC(3), .A_H_BP(3),
    .A_V_ACT(10), .A_V_FP(1), .A_V_SYNC(2), .A_V_BP(2),
    .B_H_ACT(10), .B_H_FP(1), .B_H_SYNC(2), .B_H_BP(1),
    .B_V_ACT(6),  .B_V_FP(1), .B_V_SYNC(1), .B_V_BP(2),
    .B_HPOL(1'b1), .B_VPOL(1'b1),
    .LATENCY(3)
  ) u_lat3 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .mode_sel(mode_sel),
    .hsync(hs[1]), .vsync(vs[1]), .active_video(av[1]), .pixel_x(px[1]), .pixel_y(py[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .mode_cur(mc[1])
  );

  vga_timing_gen u_dflt (
    .clk(clk), .reset(reset), .pix_en(pix_en), .mode_sel(mode_sel),
    .hsync(hs[2]), .vsync(vs[2]), .active_video(av[2]), .pixel_x(px[2]), .pixel_y(py[2]),
    .line_start(ls[2]), .frame_start(fs[2]), .mode_cur(mc[2])
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // ---------------- reference model ----------------
  function automatic int tv(int c, int m, int i);
    if (c == 2) return (m != 0) ? DB[i] : DA[i];
    return (m != 0) ? SB[i] : SA[i];
  endfunction

  function automatic bit pol_of(int c, int m);
    return (c == 1) && (m != 0);
  endfunction

  function automatic int htot(int c, int m);
    return tv(c, m, 0) + tv(c, m, 1) + tv(c, m, 2) + tv(c, m, 3);
  endfunction

  function automatic int vtot(int c, int m);
    return tv(c, m, 4) + tv(c, m, 5) + tv(c, m, 6) + tv(c, m, 7);
  endfunction

  function automatic obs_t rst_obs();
    obs_t r = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    return r;
  endfunction

  // Outputs for enabled-pixel offset t within the frame of mode m.
  function automatic obs_t ref_out(int c, int m, int t, bit en, bit st);
    obs_t r;
    int h = t % htot(c, m);
    int v = t / htot(c, m);
    int hs0 = tv(c, m, 0) + tv(c, m, 1);
    int vs0 = tv(c, m, 4) + tv(c, m, 5);
    bit hin = (h >= hs0) && (h < hs0 + tv(c, m, 2));
    bit vin = (v >= vs0) && (v < vs0 + tv(c, m, 6));
    r.hs  = hin ? pol_of(c, m) : ~pol_of(c, m);
    r.vs  = vin ? pol_of(c, m) : ~pol_of(c, m);
    r.act = (st || en) && (h < tv(c, m, 0)) && (v < tv(c, m, 4));
    r.px  = r.act ? XW'(h) : '0;
    r.py  = r.act ? YW'(v) : '0;
    r.ls  = en && (h == 0);
    r.fs  = r.ls && (v == 0);
    r.mc  = (m != 0);
    return r;
  endfunction

  int   t_m[3];
  int   md_m[3];
  bit   st_m[3];
  obs_t hist1[$];
  obs_t exp_q0[$];
  obs_t exp_q1[$];
  obs_t exp_q2[$];

  // One cycle of stimulus; the expected outputs for that cycle go to the scoreboard.
  task automatic step(input bit en, input bit ms, input bit rst);
    obs_t r;
    obs_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    pix_en   = en;
    mode_sel = ms;
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        e = rst_obs();
      end else begin
        r = ref_out(c, md_m[c], t_m[c], en, st_m[c]);
        if (c != 1) begin
          e = r;
        end else if (hist1.size() < 3) begin
          e    = rst_obs();
          e.mc = (md_m[c] != 0);
        end else begin
          e    = hist1[hist1.size() - 3];
          e.ls = e.ls & en;
          e.fs = e.fs & en;
          e.mc = (md_m[c] != 0);
        end
        if (en) begin
          if (c == 1) begin
            hist1.push_back(r);
            if (hist1.size() > 3) void'(hist1.pop_front());
          end
          st_m[c] = 1'b1;
          t_m[c]++;
          if (t_m[c] == htot(c, md_m[c]) * vtot(c, md_m[c])) begin
            t_m[c]  = 0;
            md_m[c] = int'(ms);
          end
        end
      end
      case (c)
        0:       exp_q0.push_back(e);
        1:       exp_q1.push_back(e);
        default: exp_q2.push_back(e);
      endcase
    end
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        t_m[c]  = 0;
        md_m[c] = 0;
        st_m[c] = 1'b0;
      end
      hist1.delete();
    end
    cyc++;
  endtask

  // ---------------- monitor ----------------
  function automatic obs_t obs_of(int c);
    obs_t o;
    o.hs  = hs[c];
    o.vs  = vs[c];
    o.act = av[c];
    o.px  = px[c];
    o.py  = py[c];
    o.ls  = ls[c];
    o.fs  = fs[c];
    o.mc  = mc[c];
    return o;
  endfunction

  task automatic chk_obs(input int c, input obs_t e);
    obs_t a = obs_of(c);
    total++;
    if (a === e) begin
      passed++;
    end else begin
      $display("FAIL outputs u%0d cyc %0d: got hs%b vs%b act%b x%0d y%0d ls%b fs%b mc%b, want hs%b vs%b act%b x%0d y%0d ls%b fs%b mc%b",
               c, cyc, a.hs, a.vs, a.act, a.px, a.py, a.ls, a.fs, a.mc,
               e.hs, e.vs, e.act, e.px, e.py, e.ls, e.fs, e.mc);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s cyc %0d: got %0d want %0d", name, cyc, got, want);
  endtask

  // Line measurement on the default instance, counted in enabled cycles.
  int ln_cnt   = 0;
  int hs_fall  = -1;
  int hs_len   = 0;
  bit ln_valid = 1'b0;

  always @(negedge clk) begin
    if (exp_q0.size() > 0) chk_obs(0, exp_q0.pop_front());
    if (exp_q1.size() > 0) chk_obs(1, exp_q1.pop_front());
    if (exp_q2.size() > 0) chk_obs(2, exp_q2.pop_front());
    if (reset) begin
      ln_valid = 1'b0;
    end else if (pix_en) begin
      if (ls[2]) begin
        if (ln_valid) begin
          chk_int("line_period", ln_cnt, 1344);
          chk_int("hsync_start", hs_fall, 1048);
          chk_int("hsync_width", hs_len, 136);
        end
        ln_valid = 1'b1;
        ln_cnt   = 0;
        hs_fall  = -1;
        hs_len   = 0;
      end
      if (!hs[2]) begin
        if (hs_fall < 0) hs_fall = ln_cnt;
        hs_len++;
      end
      ln_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ms = 1'b0;
    for (int c = 0; c < 3; c++) begin
      t_m[c]  = 0;
      md_m[c] = 0;
      st_m[c] = 1'b0;
    end
    // Reset with pix_en wiggling: outputs must stay idle.
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    // Mode A, continuous enable.
    for (int i = 0; i < 2100; i++) step(1'b1, 1'b0, 1'b0);
    // Request mode B mid-frame; takes effect at the next frame wrap.
    for (int i = 0; i < 1500; i++) step(1'b1, 1'b1, 1'b0);
    // Alternating enable.
    for (int i = 0; i < 200; i++) step(1'(i % 2 == 0), 1'b1, 1'b0);
    // Random enable and occasional mode requests.
    ms = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 299) == 0) ms = ~ms;
      step(1'($urandom_range(0, 9) < 6), ms, 1'b0);
    end
    // Mid-frame reset, then resume.
    for (int i = 0; i < 2; i++) step(1'($urandom_range(0, 1)), ms, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) ms = ~ms;
      step(1'($urandom_range(0, 9) < 7), ms, 1'b0);
    end
    @(negedge clk);
    #1;
    chk_int("scoreboard_drained", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
